rd_mode_picker: RTL and testbench

Parametrised rate-distortion mode selector for the intra chroma and luma prediction stages. It sequences up to NUM_MODES candidate predictions through an external reconstruct/measure engine. For each candidate it collects the SSE and rate sum, computes the RD score, and retains the best mode together with its reconstruction payload. It generalises the fixed 4-mode UV picker with:
- a runtime mode mask
- per-mode fixed costs supplied at run time
- order-independent metric collection
- score saturation
- an abort input

---
 rtl/rd_mode_picker_if.sv | 24 ++
 rtl/rd_mode_picker.sv | 174 +++++++++++++++++
 tb/tb_rd_mode_picker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_mode_picker_if.sv
// rtl/rd_mode_picker_if.sv - launch/result handshake between rd_mode_picker and the reconstruct/measure engine
interface rd_mode_picker_if #(
  parameter int MODE_W    = 2,
  parameter int PAYLOAD_W = 3152
);
  logic                 eng_start;
  logic [MODE_W-1:0]    eng_mode;
  logic                 eng_done;
  logic [PAYLOAD_W-1:0] eng_payload;
  logic                 sse_valid;
  logic [31:0]          sse;
  logic                 rate_valid;
  logic [31:0]          rate;

  modport master (
    output eng_start, eng_mode,
    input  eng_done, eng_payload, sse_valid, sse, rate_valid, rate
  );

  modport slave (
    input  eng_start, eng_mode,
    output eng_done, eng_payload, sse_valid, sse, rate_valid, rate
  );
endinterface

// File: rtl/rd_mode_picker.sv
// rtl/rd_mode_picker.sv - rate-distortion mode selector sequencing enabled modes from highest to lowest index
module rd_mode_picker #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2,
  parameter int PAYLOAD_W = 3152,
  parameter int SCORE_W   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [NUM_MODES-1:0]    mode_mask_i,
  input  logic [31:0]             lambda_i,
  input  logic [16*NUM_MODES-1:0] fixed_cost_i,
  rd_mode_picker_if.master        eng,
  output logic [MODE_W-1:0]       best_mode_o,
  output logic [SCORE_W-1:0]      best_score_o,
  output logic [PAYLOAD_W-1:0]    best_payload_o,
  output logic                    none_valid_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int PW = 81;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ISSUE = 6'b000010,
    S_WAIT  = 6'b000100,
    S_SCORE = 6'b001000,
    S_COMP  = 6'b010000,
    S_DONE  = 6'b100000
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_MODES-1:0]    mask_q;
  logic [31:0]             lambda_q;
  logic [16*NUM_MODES-1:0] fixed_cost_q;
  logic [MODE_W-1:0]       cur_q;
  logic                    got_done_q, got_sse_q, got_rate_q;
  logic [31:0]             sse_q, rate_q;
  logic [SCORE_W-1:0]      score_q;
  logic                    eng_start_q;
  logic [MODE_W-1:0]       eng_mode_q;
  logic [MODE_W-1:0]       best_mode_q;
  logic [SCORE_W-1:0]      best_score_q;
  logic [PAYLOAD_W-1:0]    best_payload_q;
  logic                    none_valid_q;

  // Returns {found, index of highest set bit}.
  function automatic logic [MODE_W:0] pick_hi(input logic [NUM_MODES-1:0] v);
    logic [MODE_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (v[i]) r = {1'b1, MODE_W'(i)};
    end
    return r;
  endfunction

  logic [NUM_MODES-1:0] lower_mask;
  logic [MODE_W:0]      first_hit, next_hit;
  logic                 all_in;
  logic [15:0]          cost_cur;
  logic [47:0]          t_cost;
  logic [PW-1:0]        p_full;
  logic [SCORE_W-1:0]   score_sat;

  assign lower_mask = mask_q & ((NUM_MODES'(1) << cur_q) - NUM_MODES'(1));
  assign first_hit  = pick_hi(mode_mask_i);
  assign next_hit   = pick_hi(lower_mask);

  // A pulse arriving in the last WAIT cycle counts toward leaving WAIT.
  assign all_in = (got_done_q | eng.eng_done) & (got_sse_q | eng.sse_valid) &
                  (got_rate_q | eng.rate_valid);

  assign cost_cur  = fixed_cost_q[{cur_q, 4'b0000} +: 16];
  assign t_cost    = {6'd0, rate_q, 10'd0} + 48'(cost_cur);
  assign p_full    = PW'(t_cost) * PW'(lambda_q) + PW'({sse_q, 8'd0});
  assign score_sat = (|p_full[PW-1:SCORE_W]) ? {SCORE_W{1'b1}} : p_full[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = first_hit[MODE_W] ? S_ISSUE : S_DONE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (all_in) state_d = S_SCORE;
      S_SCORE: state_d = S_COMP;
      S_COMP:  state_d = next_hit[MODE_W] ? S_ISSUE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q         <= '0;
      lambda_q       <= '0;
      fixed_cost_q   <= '0;
      cur_q          <= '0;
      got_done_q     <= 1'b0;
      got_sse_q      <= 1'b0;
      got_rate_q     <= 1'b0;
      sse_q          <= '0;
      rate_q         <= '0;
      score_q        <= '0;
      eng_start_q    <= 1'b0;
      eng_mode_q     <= '0;
      best_mode_q    <= '0;
      best_score_q   <= '0;
      best_payload_q <= '0;
      none_valid_q   <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      if (!abort_i) begin
        case (state_q)
          S_IDLE: if (start_i) begin
            mask_q       <= mode_mask_i;
            lambda_q     <= lambda_i;
            fixed_cost_q <= fixed_cost_i;
            best_score_q <= {SCORE_W{1'b1}};
            none_valid_q <= ~first_hit[MODE_W];
            cur_q        <= first_hit[MODE_W-1:0];
          end
          S_ISSUE: begin
            got_done_q  <= 1'b0;
            got_sse_q   <= 1'b0;
            got_rate_q  <= 1'b0;
            eng_start_q <= 1'b1;
            eng_mode_q  <= cur_q;
          end
          S_WAIT: begin
            if (eng.eng_done) got_done_q <= 1'b1;
            if (eng.sse_valid && !got_sse_q) begin
              got_sse_q <= 1'b1;
              sse_q     <= eng.sse;
            end
            if (eng.rate_valid && !got_rate_q) begin
              got_rate_q <= 1'b1;
              rate_q     <= eng.rate;
            end
          end
          S_SCORE: score_q <= score_sat;
          S_COMP: begin
            // Modes run high to low, so <= hands ties to the lower index.
            if (score_q <= best_score_q) begin
              best_score_q   <= score_q;
              best_mode_q    <= cur_q;
              best_payload_q <= eng.eng_payload;
            end
            if (next_hit[MODE_W]) cur_q <= next_hit[MODE_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign eng.eng_start  = eng_start_q & ~abort_i;
  assign eng.eng_mode   = eng_mode_q;
  assign best_mode_o    = best_mode_q;
  assign best_score_o   = best_score_q;
  assign best_payload_o = best_payload_q;
  assign none_valid_o   = none_valid_q;
endmodule

// File: tb/tb_rd_mode_picker.sv
// tb/tb_rd_mode_picker.sv - table, corner-case and randomized checks of rd_mode_picker against a score model
module tb_rd_mode_picker;
  localparam int NM = 4;
  localparam int MW = 2;
  localparam int PW = 3152;
  localparam int SW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i, abort_i;
  logic [3:0] mode_mask_i;
  logic [31:0] lambda_i;
  logic [63:0] fixed_cost_i;
  logic [MW-1:0] best_mode;
  logic [SW-1:0] best_score;
  logic [PW-1:0] best_payload;
  logic none_valid, busy, done;

  rd_mode_picker_if #(.MODE_W(MW), .PAYLOAD_W(PW)) ifc ();

  rd_mode_picker #(.NUM_MODES(NM), .MODE_W(MW), .PAYLOAD_W(PW), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .mode_mask_i(mode_mask_i), .lambda_i(lambda_i), .fixed_cost_i(fixed_cost_i),
    .eng(ifc), .best_mode_o(best_mode), .best_score_o(best_score),
    .best_payload_o(best_payload), .none_valid_o(none_valid), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [3:0][15:0] fc;
  logic [3:0][31:0] rt, ss;
  int dd[4], ds[4], dr[4];
  bit dup;
  logic [31:0] salt;
  int total, bad;

  logic [1:0]    prev_mode;
  logic [PW-1:0] prev_pay;
  logic [1:0]    m_mode;
  logic [63:0]   m_score;
  int            m_cyc, m_sig;
  int            done_cyc, first_es, act_sig;
  bit            busy_ok;
  logic [1:0]    idle_after;

  typedef struct packed {
    logic [3:0] mask; logic [31:0] lam;
    logic [3:0][15:0] fc; logic [3:0][31:0] rt; logic [3:0][31:0] ss;
    int dd; int ds; int dr; bit dup;
    logic [1:0] emode; logic [63:0] escore; int ecyc;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [PW-1:0] pay(input logic [31:0] s, input logic [1:0] m);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < PW/32; i++) p[32*i +: 32] = s ^ (32'(i) * 32'h9E3779B9) ^ {30'd0, m};
    p[PW-1 -: 16] = s[31:16] ^ {14'd0, m};
    return p;
  endfunction

  function automatic logic [63:0] model_score(input int m, input logic [31:0] lm);
    logic [127:0] s;
    s = (128'(rt[m]) * 1024 + 128'(fc[m])) * 128'(lm) + 128'(ss[m]) * 256;
    if (s > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) s = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    return s[63:0];
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkp(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act_lo=%0h exp_lo=%0h", nm, act[63:0], exp[63:0]);
    end
  endtask

  // Engine: pulses each metric a configured number of cycles after eng_start (0 = same cycle).
  initial begin
    int k;
    logic [1:0] cm;
    bit run;
    k = 0; cm = 0; run = 0;
    ifc.eng_done = 0; ifc.sse_valid = 0; ifc.rate_valid = 0;
    ifc.sse = 0; ifc.rate = 0; ifc.eng_payload = '0;
    forever begin
      @(posedge clk); #2;
      if (ifc.eng_start) begin run = 1; k = 0; cm = ifc.eng_mode; end
      else if (run) k++;
      ifc.eng_done   = run && (k == dd[cm]);
      ifc.sse_valid  = run && ((k == ds[cm]) || (dup && k == ds[cm] + 1));
      ifc.sse        = (run && k == ds[cm]) ? ss[cm] : 32'hDEADBEEF;
      ifc.rate_valid = run && (k == dr[cm]);
      ifc.rate       = (run && k == dr[cm]) ? rt[cm] : 32'hBAD00BAD;
      if (ifc.eng_done) ifc.eng_payload = pay(salt, cm);
    end
  end

  task automatic set_delays(input int a, input int b, input int c);
    for (int m = 0; m < 4; m++) begin dd[m] = a; ds[m] = b; dr[m] = c; end
  endtask

  task automatic model(input logic [3:0] mk, input logic [31:0] lm);
    logic [63:0] sc;
    bit any;
    any = 0; m_cyc = 1; m_sig = 0; m_score = '1; m_mode = prev_mode;
    for (int m = 0; m < 4; m++) begin
      if (mk[m]) begin
        sc = model_score(m, lm);
        if (!any || sc < m_score) begin m_score = sc; m_mode = 2'(m); end
        any = 1;
        m_cyc += max3(dd[m], ds[m], dr[m]) + 4;
      end
    end
    for (int m = 3; m >= 0; m--) if (mk[m]) m_sig = m_sig * 5 + m + 1;
  endtask

  // Called at posedge+1; the current cycle is cycle 0 of the run.
  task automatic do_run(input logic [3:0] mk, input logic [31:0] lm, input bit noise);
    salt = $urandom;
    done_cyc = -1; first_es = -1; act_sig = 0; busy_ok = 1;
    mode_mask_i = mk; lambda_i = lm; fixed_cost_i = fc;
    start_i = 1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start_i = noise && ($urandom_range(0, 3) == 0);
      if (ifc.eng_start) begin
        act_sig = act_sig * 5 + int'(ifc.eng_mode) + 1;
        if (first_es < 0) first_es = c;
      end
      if (!busy) busy_ok = 0;
      if (done) begin done_cyc = c; break; end
    end
    start_i = 0;
    @(posedge clk); #1;
    idle_after = {busy, done};
  endtask

  task automatic check_run(input logic [3:0] mk, input logic [31:0] lm,
                           input logic [1:0] em, input logic [63:0] es, input int ec);
    logic [PW-1:0] ep;
    model(mk, lm);
    ep = (mk != 0) ? pay(salt, em) : prev_pay;
    chk("done_cycle", done_cyc, ec);
    chk("best_mode", best_mode, em);
    chk("best_score", best_score, es);
    chkp("best_payload", best_payload, ep);
    chk("none_valid", none_valid, mk == 0);
    chk("eng_order", act_sig, m_sig);
    chk("first_eng_start", first_es, (mk != 0) ? 2 : -1);
    chk("busy_during_run", busy_ok, 1);
    chk("idle_after_done", idle_after, 0);
    prev_mode = em;
    prev_pay  = ep;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 0; start_i = 0; abort_i = 0;
    mode_mask_i = 0; lambda_i = 0; fixed_cost_i = 0;
    fc = '0; rt = '0; ss = '0; dup = 0; salt = 0;
    set_delays(1, 1, 1);
    prev_mode = 0; prev_pay = '0;

    vecs[0] = '{mask:4'hF, lam:32'd1, fc:{16'd642, 16'd439, 16'd984, 16'd302}, rt:128'd0, ss:128'd0,
                dd:1, ds:1, dr:1, dup:1'b0, emode:2'd0, escore:64'd302, ecyc:21};
    vecs[1] = '{mask:4'hF, lam:32'd3, fc:{16'd100, 16'd100, 16'd100, 16'd100},
                rt:{32'd5, 32'd5, 32'd5, 32'd5}, ss:{32'd7, 32'd7, 32'd7, 32'd7},
                dd:2, ds:1, dr:0, dup:1'b0, emode:2'd0, escore:64'd17452, ecyc:25};
    vecs[2] = '{mask:4'h5, lam:32'd2, fc:{16'd0, 16'd5, 16'd0, 16'd10},
                rt:{32'd0, 32'd1, 32'd0, 32'd1}, ss:{32'd0, 32'd300, 32'd0, 32'd0},
                dd:0, ds:0, dr:0, dup:1'b0, emode:2'd0, escore:64'd2068, ecyc:9};
    vecs[3] = '{mask:4'h1, lam:32'hFFFFFFFF, fc:64'd0, rt:{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF}, ss:128'd0,
                dd:1, ds:1, dr:1, dup:1'b0, emode:2'd0, escore:64'hFFFFFFFFFFFFFFFF, ecyc:6};
    vecs[4] = '{mask:4'h9, lam:32'hFFFFFFFF, fc:{16'd0, 16'd0, 16'd0, 16'd65535},
                rt:{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, ss:{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF},
                dd:0, ds:1, dr:1, dup:1'b0, emode:2'd0, escore:64'h000100FEFFFEFF01, ecyc:11};
    vecs[5] = '{mask:4'hE, lam:32'd1, fc:{16'd400, 16'd400, 16'd500, 16'd0}, rt:128'd0, ss:128'd0,
                dd:3, ds:0, dr:0, dup:1'b1, emode:2'd2, escore:64'd400, ecyc:22};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_start", ifc.eng_start, 0);
    chk("rst_eng_mode", ifc.eng_mode, 0);
    chk("rst_best_mode", best_mode, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_none_valid", none_valid, 0);
    chkp("rst_best_payload", best_payload, '0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      fc = vecs[i].fc; rt = vecs[i].rt; ss = vecs[i].ss;
      set_delays(vecs[i].dd, vecs[i].ds, vecs[i].dr);
      dup = vecs[i].dup;
      do_run(vecs[i].mask, vecs[i].lam, 1'b0);
      check_run(vecs[i].mask, vecs[i].lam, vecs[i].emode, vecs[i].escore, vecs[i].ecyc);
    end

    // Empty mask right after a mode-2 win: result registers must not move.
    do_run(4'h0, 32'd9, 1'b0);
    check_run(4'h0, 32'd9, 2'd2, 64'hFFFFFFFFFFFFFFFF, 1);

    // Abort in the eng_start cycle of mode 2.
    fc = vecs[0].fc; rt = '0; ss = '0; set_delays(1, 1, 1); dup = 0;
    salt = $urandom;
    mode_mask_i = 4'hF; lambda_i = 32'd1; fixed_cost_i = fc;
    start_i = 1;
    for (int c = 1; c <= 7; c++) begin @(posedge clk); #1; start_i = 0; end
    chk("abort_pre_eng_start", ifc.eng_start, 1);
    chk("abort_pre_eng_mode", ifc.eng_mode, 2);
    abort_i = 1; #1;
    chk("abort_eng_start_forced", ifc.eng_start, 0);
    @(posedge clk); #1;
    abort_i = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_best_mode", best_mode, 3);
    chk("abort_best_score", best_score, 642);
    chkp("abort_best_payload", best_payload, pay(salt, 2'd3));
    prev_mode = 3; prev_pay = pay(salt, 2'd3);
    busy_ok = 1;
    repeat (4) begin @(posedge clk); #1; if (done || busy) busy_ok = 0; end
    chk("abort_stays_idle", busy_ok, 1);
    start_i = 1; abort_i = 1;
    @(posedge clk); #1;
    start_i = 0; abort_i = 0;
    chk("abort_beats_start", busy, 0);
    do_run(4'hF, 32'd1, 1'b0);
    check_run(4'hF, 32'd1, 2'd0, 64'd302, 21);

    for (int r = 0; r < 30; r++) begin
      logic [3:0] mk;
      logic [31:0] lm;
      mk = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      lm = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      for (int m = 0; m < 4; m++) begin
        fc[m] = 16'($urandom);
        rt[m] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50));
        ss[m] = $urandom;
        dd[m] = $urandom_range(0, 3);
        ds[m] = $urandom_range(0, 3);
        dr[m] = $urandom_range(0, 3);
      end
      dup = 1'($urandom_range(0, 1));
      do_run(mk, lm, 1'b1);
      model(mk, lm);
      check_run(mk, lm, m_mode, m_score, m_cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
